// File: rtl/battleship_pkg.sv
// Shared types and default board dimensions for the battleship game blocks.
//   cell_t          : encoding of one board cell as stored and shown on the display port
//   tracker_state_t : command sequencer states of board_tracker
//   BOARD_*         : default board geometry and fleet size
package battleship_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        HIT   = 2'b10,
        MISS  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHECK  = 2'b01,
        COMMIT = 2'b10
    } tracker_state_t;

    localparam int BOARD_ROWS  = 5;
    localparam int BOARD_COLS  = 5;
    localparam int BOARD_SHIPS = 5;

endpackage

// File: rtl/board_tracker.sv
// Per-player board store and shot resolver.
// Records ship cells during placement. During play it resolves shots as
// HIT / MISS / REPEAT and counts the ship cells still afloat.
// Ports:
//   clk, reset (async, active-high), clear (sync board wipe)
//   place_en / shoot_en with row/col : one command at a time, ignored while busy
//   busy                             : command in flight
//   place_ok / place_err             : one-cycle placement result pulses
//   shot_valid, shot_hit, shot_repeat: one-cycle shot result (hit/repeat qualified by shot_valid)
//   ships_left, fleet_alive          : ship cells not yet hit, and (ships_left != 0)
//   rd_row / rd_col -> rd_cell       : combinational display read, EMPTY when out of range
module board_tracker
    import battleship_pkg::*;
#(
    parameter int ROWS      = BOARD_ROWS,
    parameter int COLS      = BOARD_COLS,
    parameter int MAX_SHIPS = BOARD_SHIPS,
    parameter int RW        = $clog2(ROWS),
    parameter int CW        = $clog2(COLS),
    parameter int SW        = $clog2(MAX_SHIPS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          place_en,
    input  logic          shoot_en,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    output logic          busy,
    output logic          place_ok,
    output logic          place_err,
    output logic          shot_valid,
    output logic          shot_hit,
    output logic          shot_repeat,
    output logic [SW-1:0] ships_left,
    output logic          fleet_alive,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output cell_t         rd_cell
);

    localparam int CELLS = ROWS * COLS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    // Coordinates are compared as integers so that a board whose size is an
    // exact power of two never has its bound truncated to zero.
    function automatic logic coord_in_range(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (int'(r) < ROWS) && (int'(c) < COLS);
    endfunction

    // Row-major flat index; only meaningful for in-range coordinates.
    function automatic logic [IW-1:0] cell_index(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * IW'(COLS) + IW'(c);
    endfunction

    tracker_state_t state_q, state_d;
    logic           op_shot_q, op_shot_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [IW-1:0]  idx_q, idx_d;
    cell_t          cell_q, cell_d;
    logic           in_range_q, in_range_d;
    logic [SW-1:0]  ships_left_q, ships_left_d;
    logic           fleet_alive_q, fleet_alive_d;
    logic           locked_q, locked_d;
    logic           busy_q, busy_d;
    logic           place_ok_q, place_ok_d;
    logic           place_err_q, place_err_d;
    logic           shot_valid_q, shot_valid_d;
    logic           shot_hit_q, shot_hit_d;
    logic           shot_repeat_q, shot_repeat_d;

    cell_t          board_q [CELLS];

    logic           wr_en_s;
    cell_t          wr_cell_s;
    logic           wipe_s;
    logic           chk_in_range_s;
    logic [IW-1:0]  chk_idx_s;

    assign chk_in_range_s = coord_in_range(row_q, col_q);
    assign chk_idx_s      = chk_in_range_s ? cell_index(row_q, col_q) : {IW{1'b0}};

    // Command sequencer: accept, look up the target cell, then commit and report.
    always_comb begin
        state_d       = state_q;
        op_shot_d     = op_shot_q;
        row_d         = row_q;
        col_d         = col_q;
        idx_d         = idx_q;
        cell_d        = cell_q;
        in_range_d    = in_range_q;
        ships_left_d  = ships_left_q;
        locked_d      = locked_q;
        place_ok_d    = 1'b0;
        place_err_d   = 1'b0;
        shot_valid_d  = 1'b0;
        shot_hit_d    = 1'b0;
        shot_repeat_d = 1'b0;
        wr_en_s       = 1'b0;
        wr_cell_s     = EMPTY;
        wipe_s        = 1'b0;

        if (clear) begin
            // New game: drop any in-flight command without a result pulse.
            wipe_s       = 1'b1;
            state_d      = IDLE;
            ships_left_d = {SW{1'b0}};
            locked_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (shoot_en) begin
                        // A shot wins over a simultaneous placement and closes placement.
                        op_shot_d = 1'b1;
                        row_d     = row;
                        col_d     = col;
                        locked_d  = 1'b1;
                        state_d   = CHECK;
                    end else if (place_en) begin
                        op_shot_d = 1'b0;
                        row_d     = row;
                        col_d     = col;
                        state_d   = CHECK;
                    end else begin
                        state_d   = IDLE;
                    end
                end
                CHECK: begin
                    in_range_d = chk_in_range_s;
                    idx_d      = chk_idx_s;
                    cell_d     = chk_in_range_s ? board_q[chk_idx_s] : EMPTY;
                    state_d    = COMMIT;
                end
                COMMIT: begin
                    state_d = IDLE;
                    if (op_shot_q) begin
                        shot_valid_d = 1'b1;
                        if (!in_range_q) begin
                            shot_repeat_d = 1'b1;
                        end else begin
                            case (cell_q)
                                SHIP: begin
                                    // A SHIP cell exists only while ships_left > 0, so no underflow.
                                    wr_en_s      = 1'b1;
                                    wr_cell_s    = HIT;
                                    ships_left_d = ships_left_q - SW'(1);
                                    shot_hit_d   = 1'b1;
                                end
                                EMPTY: begin
                                    wr_en_s   = 1'b1;
                                    wr_cell_s = MISS;
                                end
                                default: begin
                                    shot_repeat_d = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        if (!in_range_q || (cell_q == SHIP) ||
                            (ships_left_q == SW'(MAX_SHIPS)) || locked_q) begin
                            place_err_d = 1'b1;
                        end else begin
                            wr_en_s      = 1'b1;
                            wr_cell_s    = SHIP;
                            ships_left_d = ships_left_q + SW'(1);
                            place_ok_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Derived from the next count so fleet_alive moves in the same cycle as ships_left.
        fleet_alive_d = (ships_left_d != {SW{1'b0}});
        busy_d        = (state_d != IDLE);
    end

    // Sequencer, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_shot_q     <= 1'b0;
            row_q         <= {RW{1'b0}};
            col_q         <= {CW{1'b0}};
            idx_q         <= {IW{1'b0}};
            cell_q        <= EMPTY;
            in_range_q    <= 1'b0;
            ships_left_q  <= {SW{1'b0}};
            fleet_alive_q <= 1'b0;
            locked_q      <= 1'b0;
            busy_q        <= 1'b0;
            place_ok_q    <= 1'b0;
            place_err_q   <= 1'b0;
            shot_valid_q  <= 1'b0;
            shot_hit_q    <= 1'b0;
            shot_repeat_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_shot_q     <= op_shot_d;
            row_q         <= row_d;
            col_q         <= col_d;
            idx_q         <= idx_d;
            cell_q        <= cell_d;
            in_range_q    <= in_range_d;
            ships_left_q  <= ships_left_d;
            fleet_alive_q <= fleet_alive_d;
            locked_q      <= locked_d;
            busy_q        <= busy_d;
            place_ok_q    <= place_ok_d;
            place_err_q   <= place_err_d;
            shot_valid_q  <= shot_valid_d;
            shot_hit_q    <= shot_hit_d;
            shot_repeat_q <= shot_repeat_d;
        end
    end

    // Board cell array: wiped on reset/clear, single write at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) begin
                board_q[i] <= EMPTY;
            end
        end else if (wipe_s) begin
            for (int i = 0; i < CELLS; i++) begin
                board_q[i] <= EMPTY;
            end
        end else if (wr_en_s) begin
            board_q[idx_q] <= wr_cell_s;
        end
    end

    // Display read port.
    always_comb begin
        rd_cell = EMPTY;
        if (coord_in_range(rd_row, rd_col)) begin
            rd_cell = board_q[cell_index(rd_row, rd_col)];
        end else begin
            rd_cell = EMPTY;
        end
    end

    assign busy        = busy_q;
    assign place_ok    = place_ok_q;
    assign place_err   = place_err_q;
    assign shot_valid  = shot_valid_q;
    assign shot_hit    = shot_hit_q;
    assign shot_repeat = shot_repeat_q;
    assign ships_left  = ships_left_q;
    assign fleet_alive = fleet_alive_q;

endmodule

// File: tb/tb_board_tracker.sv
// Self-checking bench for board_tracker: directed literal checks plus a
// randomized run, all compared every cycle against a behavioural board model.
module tb_board_tracker;
    import battleship_pkg::*;

    localparam int ROWS      = 5;
    localparam int COLS      = 5;
    localparam int MAX_SHIPS = 5;
    localparam int RW        = 3;
    localparam int CW        = 3;
    localparam int SW        = 3;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          clear    = 1'b0;
    logic          place_en = 1'b0;
    logic          shoot_en = 1'b0;
    logic [RW-1:0] row      = '0;
    logic [CW-1:0] col      = '0;
    logic [RW-1:0] rd_row   = '0;
    logic [CW-1:0] rd_col   = '0;
    logic          busy, place_ok, place_err, shot_valid, shot_hit, shot_repeat, fleet_alive;
    logic [SW-1:0] ships_left;
    cell_t         rd_cell;

    int vectors     = 0;
    int miscompares = 0;

    always #50 clk = ~clk;

    board_tracker #(.ROWS(ROWS), .COLS(COLS), .MAX_SHIPS(MAX_SHIPS)) dut (
        .clk(clk), .reset(reset), .clear(clear), .place_en(place_en), .shoot_en(shoot_en),
        .row(row), .col(col), .busy(busy), .place_ok(place_ok), .place_err(place_err),
        .shot_valid(shot_valid), .shot_hit(shot_hit), .shot_repeat(shot_repeat),
        .ships_left(ships_left), .fleet_alive(fleet_alive),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    cell_t mb [ROWS][COLS];
    int    m_ships, m_inflight, p_r, p_c;
    bit    m_locked, p_shot;
    bit    e_ok, e_err, e_sv, e_hit, e_rep;

    task automatic m_wipe();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = EMPTY;
        m_ships = 0; m_locked = 0; m_inflight = 0;
    endtask

    function automatic cell_t m_rd(input int r, input int c);
        if (r < ROWS && c < COLS) return mb[r][c];
        return EMPTY;
    endfunction

    task automatic m_resolve();
        bit inr;
        inr = (p_r < ROWS) && (p_c < COLS);
        if (p_shot) begin
            e_sv = 1;
            if (!inr) e_rep = 1;
            else if (mb[p_r][p_c] == SHIP) begin mb[p_r][p_c] = HIT; m_ships--; e_hit = 1; end
            else if (mb[p_r][p_c] == EMPTY) mb[p_r][p_c] = MISS;
            else e_rep = 1;
        end else begin
            if (!inr || mb[p_r][p_c] == SHIP || m_ships == MAX_SHIPS || m_locked) e_err = 1;
            else begin mb[p_r][p_c] = SHIP; m_ships++; e_ok = 1; end
        end
    endtask

    task automatic m_step();
        e_ok = 0; e_err = 0; e_sv = 0; e_hit = 0; e_rep = 0;
        if (reset) m_wipe();
        else if (clear) m_wipe();
        else if (m_inflight > 0) begin
            m_inflight--;
            if (m_inflight == 0) m_resolve();
        end else if (shoot_en) begin
            p_shot = 1; p_r = int'(row); p_c = int'(col); m_locked = 1; m_inflight = 2;
        end else if (place_en) begin
            p_shot = 0; p_r = int'(row); p_c = int'(col); m_inflight = 2;
        end
    endtask

    initial begin
        m_wipe();
        e_ok = 0; e_err = 0; e_sv = 0; e_hit = 0; e_rep = 0;
        forever begin
            @(posedge clk or posedge reset);
            m_step();
        end
    end

    // Every-cycle compare of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", int'(busy), int'(m_inflight != 0));
            chk("place_ok", int'(place_ok), int'(e_ok));
            chk("place_err", int'(place_err), int'(e_err));
            chk("shot_valid", int'(shot_valid), int'(e_sv));
            if (e_sv) begin
                chk("shot_hit", int'(shot_hit), int'(e_hit));
                chk("shot_repeat", int'(shot_repeat), int'(e_rep));
            end
            chk("ships_left", int'(ships_left), m_ships);
            chk("fleet_alive", int'(fleet_alive), int'(m_ships != 0));
            chk("rd_cell", int'(rd_cell), int'(m_rd(int'(rd_row), int'(rd_col))));
        end
    end

    initial begin
        #(100 * 40000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed helpers ----------------
    localparam logic [4:0] R_OK   = 5'b10000;
    localparam logic [4:0] R_ERR  = 5'b01000;
    localparam logic [4:0] R_MISS = 5'b00100;
    localparam logic [4:0] R_HIT  = 5'b00110;
    localparam logic [4:0] R_REP  = 5'b00101;

    // res = {place_ok, place_err, shot_valid, shot_hit, shot_repeat} at the pulse cycle
    task automatic cmd(input logic pl, input logic sh, input logic cl, input int r, input int c,
                       output logic [4:0] res, output int sl, output int fl);
        @(negedge clk); #1;
        place_en = pl; shoot_en = sh; clear = cl; row = RW'(r); col = CW'(c);
        @(negedge clk); #1;
        place_en = 1'b0; shoot_en = 1'b0; clear = 1'b0;
        res = 5'b00000; sl = -1; fl = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (place_ok || place_err || shot_valid) begin
                res = {place_ok, place_err, shot_valid, shot_hit, shot_repeat};
                sl  = int'(ships_left);
                fl  = int'(fleet_alive);
                break;
            end
        end
    endtask

    task automatic rdchk(input string name, input int r, input int c, input cell_t exp);
        #2;
        rd_row = RW'(r); rd_col = CW'(c);
        #1;
        chk(name, int'(rd_cell), int'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] res;
        int sl, fl, np;

        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ships", int'(ships_left), 0);
        chk("rst_fleet", int'(fleet_alive), 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                rdchk("rst_cell", r, c, EMPTY);

        cmd(1, 0, 0, 0, 0, res, sl, fl); chk("place00", int'(res), int'(R_OK));
        cmd(1, 0, 0, 0, 1, res, sl, fl); chk("place01", int'(res), int'(R_OK));
        cmd(1, 0, 0, 2, 3, res, sl, fl); chk("place23", int'(res), int'(R_OK));
        chk("ships3", sl, 3);
        chk("fleet3", fl, 1);
        rdchk("cell23", 2, 3, SHIP);
        cmd(1, 0, 0, 0, 0, res, sl, fl); chk("replace00", int'(res), int'(R_ERR));
        chk("ships_after_dup", sl, 3);
        cmd(1, 0, 0, 5, 0, res, sl, fl); chk("place_row5", int'(res), int'(R_ERR));

        cmd(0, 1, 0, 0, 0, res, sl, fl); chk("shoot00", int'(res), int'(R_HIT));
        chk("ships2", sl, 2);
        rdchk("cell00_hit", 0, 0, HIT);
        cmd(0, 1, 0, 4, 4, res, sl, fl); chk("shoot44", int'(res), int'(R_MISS));
        rdchk("cell44_miss", 4, 4, MISS);
        cmd(0, 1, 0, 4, 4, res, sl, fl); chk("shoot44_again", int'(res), int'(R_REP));
        cmd(0, 1, 0, 7, 2, res, sl, fl); chk("shoot_oor", int'(res), int'(R_REP));
        cmd(1, 0, 0, 1, 1, res, sl, fl); chk("place_locked", int'(res), int'(R_ERR));
        cmd(0, 1, 0, 0, 1, res, sl, fl); chk("shoot01", int'(res), int'(R_HIT));
        chk("ships1", sl, 1);
        cmd(0, 1, 0, 2, 3, res, sl, fl); chk("shoot23", int'(res), int'(R_HIT));
        chk("ships0", sl, 0);
        chk("fleet_drop", fl, 0);

        cmd(0, 0, 1, 0, 0, res, sl, fl); chk("clear_nopulse", int'(res), 0);
        cmd(1, 1, 0, 1, 1, res, sl, fl); chk("place_and_shoot", int'(res), int'(R_MISS));
        rdchk("cell11_miss", 1, 1, MISS);

        // shoot while busy is ignored
        np = 0;
        @(negedge clk); #1 shoot_en = 1'b1; row = 3'd2; col = 3'd2;
        @(negedge clk); np += int'(shot_valid); #1 row = 3'd3; col = 3'd3;
        @(negedge clk); np += int'(shot_valid);
        @(negedge clk); np += int'(shot_valid); #1 shoot_en = 1'b0;
        for (int k = 0; k < 6; k++) begin @(negedge clk); np += int'(shot_valid); end
        chk("busy_ignored_pulses", np, 1);
        rdchk("cell22_miss", 2, 2, MISS);
        rdchk("cell33_empty", 3, 3, EMPTY);

        // clear during CHECK drops the shot
        np = 0;
        @(negedge clk); #1 shoot_en = 1'b1; row = 3'd0; col = 3'd0;
        @(negedge clk); #1 shoot_en = 1'b0; clear = 1'b1;
        @(negedge clk); #1 clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); np += int'(shot_valid) + int'(place_ok) + int'(place_err);
        end
        chk("clear_check_pulses", np, 0);
        chk("clear_check_ships", int'(ships_left), 0);
        rdchk("clear_cell11", 1, 1, EMPTY);
        cmd(1, 0, 0, 1, 1, res, sl, fl); chk("place_unlocked", int'(res), int'(R_OK));

        for (int c = 0; c < 4; c++) begin
            cmd(1, 0, 0, 2, c, res, sl, fl); chk("place_fill", int'(res), int'(R_OK));
        end
        chk("ships5", sl, 5);
        cmd(1, 0, 0, 3, 0, res, sl, fl); chk("place_sixth", int'(res), int'(R_ERR));
        chk("ships_still5", sl, 5);

        // async reset during COMMIT
        cmd(0, 0, 1, 0, 0, res, sl, fl);
        np = 0;
        @(negedge clk); #1 place_en = 1'b1; row = 3'd4; col = 3'd4;
        @(negedge clk); #1 place_en = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); np += int'(place_ok) + int'(place_err);
        end
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); np += int'(place_ok) + int'(place_err);
        end
        chk("rst_commit_pulses", np, 0);
        chk("rst_commit_ships", int'(ships_left), 0);
        chk("rst_commit_busy", int'(busy), 0);
        rdchk("rst_commit_cell44", 4, 4, EMPTY);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            automatic int x = $urandom_range(0, 999);
            automatic int sp = ((n % 120) < 40) ? 5 : 45;
            @(negedge clk); #1;
            clear    = (x < 8) || ((n % 120) == 119);
            reset    = (x >= 997);
            shoot_en = ($urandom_range(0, 99) < sp);
            place_en = ($urandom_range(0, 99) < 45);
            row      = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(5, 7)) : RW'($urandom_range(0, 4));
            col      = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(5, 7)) : CW'($urandom_range(0, 4));
            rd_row   = RW'($urandom_range(0, 7));
            rd_col   = CW'($urandom_range(0, 7));
        end
        @(negedge clk); #1;
        clear = 1'b0; reset = 1'b0; shoot_en = 1'b0; place_en = 1'b0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
